// File: rtl/bp_fe_ras_pkg.sv
// Shared types and constants for the return-address-stack controller.
package bp_fe_ras_pkg;

  typedef enum logic [0:0] {
    e_ras_run    = 1'b0,
    e_ras_unwind = 1'b1
  } ras_state_e;

  localparam int unsigned stat_cnt_width_gp = 32;

  function automatic logic [stat_cnt_width_gp-1:0] stat_sat_inc
    (input logic [stat_cnt_width_gp-1:0] v);
    return (&v) ? v : v + stat_cnt_width_gp'(1);
  endfunction

endpackage

// File: rtl/bp_fe_ras_depth_ctr.sv
// Saturating up/down depth counter in [0, max_p] with a synchronous load.
module bp_fe_ras_depth_ctr #(
  parameter int unsigned max_p   = 8,
  parameter int unsigned width_p = $clog2(max_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_v_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (load_v_i) begin
      count_o <= load_val_i;
    end else if (inc_i && !dec_i && (count_o != width_p'(max_p))) begin
      count_o <= count_o + width_p'(1);
    end else if (dec_i && !inc_i && (count_o != '0)) begin
      count_o <= count_o - width_p'(1);
    end
  end

endmodule

// File: rtl/bp_fe_ras_ctrl.sv
// Return-address-stack controller: speculative/committed depth tracking and redirect unwind.
// Optional statistics counters are enabled with `define BP_FE_RAS_CTRL_STATS_EN.
module bp_fe_ras_ctrl
  import bp_fe_ras_pkg::*;
#(
  parameter int unsigned vaddr_width_p  = 39,
  parameter int unsigned els_p          = 8,
  parameter int unsigned depth_width_lp = $clog2(els_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          call_v_i,
  input  logic [vaddr_width_p-1:0]      call_ret_addr_i,
  input  logic                          ret_v_i,
  output logic                          ready_o,
  output logic [vaddr_width_p-1:0]      ret_tgt_o,
  output logic                          ret_tgt_v_o,
  input  logic                          commit_call_i,
  input  logic                          commit_ret_i,
  input  logic                          redirect_i,
`ifdef BP_FE_RAS_CTRL_STATS_EN
  output logic [stat_cnt_width_gp-1:0]  overflow_cnt_o,
  output logic [stat_cnt_width_gp-1:0]  underflow_cnt_o,
  output logic [stat_cnt_width_gp-1:0]  unwind_cnt_o,
`endif
  output logic                          push_o,
  output logic                          pop_o,
  output logic [vaddr_width_p-1:0]      w_data_o,
  input  logic [vaddr_width_p-1:0]      r_data_i
);

  ras_state_e                state, state_n;
  logic [depth_width_lp-1:0] spec_depth, commit_depth;
  logic                      spec_inc, spec_dec, spec_load;
  logic                      overflow, underflow, unwind_start;

  bp_fe_ras_depth_ctr #(.max_p(els_p), .width_p(depth_width_lp)) spec_ctr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_v_i   (spec_load),
    .load_val_i (commit_depth),
    .inc_i      (spec_inc),
    .dec_i      (spec_dec),
    .count_o    (spec_depth)
  );

  bp_fe_ras_depth_ctr #(.max_p(els_p), .width_p(depth_width_lp)) commit_ctr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_v_i   (1'b0),
    .load_val_i ('0),
    .inc_i      (commit_call_i),
    .dec_i      (commit_ret_i),
    .count_o    (commit_depth)
  );

  assign ready_o  = (state == e_ras_run);
  assign w_data_o = call_ret_addr_i;

  // Outputs are gated by reset_i so nothing reaches the storage while reset is held.
  always_comb begin
    state_n      = state;
    push_o       = 1'b0;
    pop_o        = 1'b0;
    ret_tgt_v_o  = 1'b0;
    ret_tgt_o    = r_data_i;
    spec_inc     = 1'b0;
    spec_dec     = 1'b0;
    spec_load    = 1'b0;
    overflow     = 1'b0;
    underflow    = 1'b0;
    unwind_start = 1'b0;
    if (reset_i) begin
      state_n = e_ras_run;
    end else if (state == e_ras_run) begin
      if (redirect_i) begin
        if (spec_depth > commit_depth) begin
          state_n      = e_ras_unwind;
          unwind_start = 1'b1;
        end else begin
          spec_load = 1'b1;
        end
      end else if (call_v_i && ret_v_i) begin
        push_o      = 1'b1;
        pop_o       = 1'b1;
        ret_tgt_v_o = 1'b1;
        ret_tgt_o   = call_ret_addr_i;
      end else if (call_v_i) begin
        if (spec_depth < depth_width_lp'(els_p)) begin
          push_o   = 1'b1;
          spec_inc = 1'b1;
        end else begin
          overflow = 1'b1;
        end
      end else if (ret_v_i) begin
        if (spec_depth != '0) begin
          pop_o       = 1'b1;
          ret_tgt_v_o = 1'b1;
          spec_dec    = 1'b1;
        end else begin
          underflow = 1'b1;
        end
      end
    end else begin
      // Target is always the live commit_depth, so a redirect here needs no extra handling.
      if (spec_depth > commit_depth) begin
        pop_o    = 1'b1;
        spec_dec = 1'b1;
        if ((spec_depth - depth_width_lp'(1)) <= commit_depth) state_n = e_ras_run;
      end else begin
        state_n = e_ras_run;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= e_ras_run;
    else         state <= state_n;
  end

`ifdef BP_FE_RAS_CTRL_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_cnt_o  <= '0;
      underflow_cnt_o <= '0;
      unwind_cnt_o    <= '0;
    end else begin
      if (overflow)     overflow_cnt_o  <= stat_sat_inc(overflow_cnt_o);
      if (underflow)    underflow_cnt_o <= stat_sat_inc(underflow_cnt_o);
      if (unwind_start) unwind_cnt_o    <= stat_sat_inc(unwind_cnt_o);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{overflow, underflow, unwind_start};
`endif

endmodule

// File: tb/tb_bp_fe_ras_ctrl.sv
// Scoreboard bench for bp_fe_ras_ctrl: stimulus queues expected per-cycle outputs, a negedge monitor checks them.
module tb_bp_fe_ras_ctrl;
  import bp_fe_ras_pkg::*;

  localparam int unsigned VW  = 39;
  localparam int unsigned ELS = 8;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          call_v_i, ret_v_i, commit_call_i, commit_ret_i, redirect_i;
  logic [VW-1:0] call_ret_addr_i;
  logic          ready_o, ret_tgt_v_o, push_o, pop_o;
  logic [VW-1:0] ret_tgt_o, w_data_o, r_data_i;
`ifdef BP_FE_RAS_CTRL_STATS_EN
  logic [stat_cnt_width_gp-1:0] overflow_cnt_o, underflow_cnt_o, unwind_cnt_o;
`endif

  bp_fe_ras_ctrl #(.vaddr_width_p(VW), .els_p(ELS)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .call_v_i        (call_v_i),
    .call_ret_addr_i (call_ret_addr_i),
    .ret_v_i         (ret_v_i),
    .ready_o         (ready_o),
    .ret_tgt_o       (ret_tgt_o),
    .ret_tgt_v_o     (ret_tgt_v_o),
    .commit_call_i   (commit_call_i),
    .commit_ret_i    (commit_ret_i),
    .redirect_i      (redirect_i),
`ifdef BP_FE_RAS_CTRL_STATS_EN
    .overflow_cnt_o  (overflow_cnt_o),
    .underflow_cnt_o (underflow_cnt_o),
    .unwind_cnt_o    (unwind_cnt_o),
`endif
    .push_o          (push_o),
    .pop_o           (pop_o),
    .w_data_o        (w_data_o),
    .r_data_i        (r_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural stack storage driven by the controller's push/pop interface.
  logic [VW-1:0] mem [0:ELS-1];
  int            sp;
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sp <= 0;
    else if (push_o && pop_o) begin
      if (sp > 0) mem[sp-1] <= w_data_o;
    end else if (push_o) begin
      if (sp < int'(ELS)) begin
        mem[sp] <= w_data_o;
        sp      <= sp + 1;
      end
    end else if (pop_o && sp > 0) sp <= sp - 1;
  end
  assign r_data_i = (sp > 0) ? mem[sp-1] : '0;

  typedef struct {
    string         name;
    logic          ready, push, pop, tv;
    logic [VW-1:0] tgt, wdata;
    int            depth, cdepth;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input string field, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.name, "ready_o",     64'(ready_o),     64'(e.ready));
      chk(e.name, "push_o",      64'(push_o),      64'(e.push));
      chk(e.name, "pop_o",       64'(pop_o),       64'(e.pop));
      chk(e.name, "ret_tgt_v_o", 64'(ret_tgt_v_o), 64'(e.tv));
      chk(e.name, "spec_depth",  64'(dut.spec_depth),   64'(e.depth));
      chk(e.name, "commit_depth",64'(dut.commit_depth), 64'(e.cdepth));
      if (e.tv)   chk(e.name, "ret_tgt_o", 64'(ret_tgt_o), 64'(e.tgt));
      if (e.push) chk(e.name, "w_data_o",  64'(w_data_o),  64'(e.wdata));
    end
  end

  // Inputs: call, addr, ret, commit_call, commit_ret, redirect, mid-cycle reset.
  // Expected (pre-edge): ready, push, pop, tgt_v, tgt, spec_depth, commit_depth.
  task automatic step(input string name, input logic c, input logic [VW-1:0] a, input logic r,
                      input logic cc, input logic cr, input logic rd, input logic rst,
                      input logic er, input logic ep, input logic eo, input logic ev,
                      input logic [VW-1:0] et, input int ed, input int ecd);
    exp_t e;
    @(posedge clk_i);
    #1;
    call_v_i = c; call_ret_addr_i = a; ret_v_i = r;
    commit_call_i = cc; commit_ret_i = cr; redirect_i = rd;
    e.name = name; e.ready = er; e.push = ep; e.pop = eo; e.tv = ev;
    e.tgt = et; e.wdata = a; e.depth = ed; e.cdepth = ecd;
    exp_q.push_back(e);
    if (rst) begin
      #1;
      reset_i = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    call_v_i = 0; ret_v_i = 0; commit_call_i = 0; commit_ret_i = 0; redirect_i = 0;
    call_ret_addr_i = '0;
  endtask

  // Reset held for a cycle with active call/ret/redirect: no storage traffic may appear.
  task automatic do_reset(input string name);
    step(name, 1, VW'('h77), 1, 1, 0, 1, 1, 1, 0, 0, 0, '0, 0, 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    idle_inputs();
  endtask

  task automatic call(input string name, input logic [VW-1:0] a, input int d, input int cd);
    step(name, 1, a, 0, 0, 0, 0, 0, 1, (d < int'(ELS)), 0, 0, '0, d, cd);
  endtask

  task automatic idle(input string name, input int d, input int cd);
    step(name, 0, '0, 0, 0, 0, 0, 0, 1, 0, 0, 0, '0, d, cd);
  endtask

  initial begin
    reset_i = 1'b1;
    idle_inputs();

    // LIFO order and underflow
    do_reset("rst0");
    call("t1_call0", VW'('h100), 0, 0);
    call("t1_call1", VW'('h200), 1, 0);
    call("t1_call2", VW'('h300), 2, 0);
    step("t1_ret0", 0, '0, 1, 0, 0, 0, 0, 1, 0, 1, 1, VW'('h300), 3, 0);
    step("t1_ret1", 0, '0, 1, 0, 0, 0, 0, 1, 0, 1, 1, VW'('h200), 2, 0);
    step("t1_ret2", 0, '0, 1, 0, 0, 0, 0, 1, 0, 1, 1, VW'('h100), 1, 0);
    step("t1_ret_under", 0, '0, 1, 0, 0, 0, 0, 1, 0, 0, 0, '0, 0, 0);
    idle("t1_idle", 0, 0);
`ifdef BP_FE_RAS_CTRL_STATS_EN
    @(negedge clk_i);
    chk("t1", "underflow_cnt_o", 64'(underflow_cnt_o), 64'd1);
`endif

    // Overflow: ninth call is dropped
    do_reset("rst1");
    for (int i = 0; i < 9; i++)
      call("t2_call", VW'('h1000 + i), (i < 8) ? i : 8, 0);
    idle("t2_idle", 8, 0);
`ifdef BP_FE_RAS_CTRL_STATS_EN
    @(negedge clk_i);
    chk("t2", "overflow_cnt_o", 64'(overflow_cnt_o), 64'd1);
`endif

    // Same-cycle call and return, at depth 2 and at depth 0
    do_reset("rst2");
    call("t3_call0", VW'('h10), 0, 0);
    call("t3_call1", VW'('h20), 1, 0);
    step("t3_callret", 1, VW'('h440), 1, 0, 0, 0, 0, 1, 1, 1, 1, VW'('h440), 2, 0);
    idle("t3_idle", 2, 0);
    step("t3_ret0", 0, '0, 1, 0, 0, 0, 0, 1, 0, 1, 1, VW'('h440), 2, 0);
    step("t3_ret1", 0, '0, 1, 0, 0, 0, 0, 1, 0, 1, 1, VW'('h10), 1, 0);
    step("t3_callret0", 1, VW'('h55), 1, 0, 0, 0, 0, 1, 1, 1, 1, VW'('h55), 0, 0);
    idle("t3_idle0", 0, 0);

    // Redirect unwind from 5 down to commit depth 2 (redirect repeated mid-unwind)
    do_reset("rst3");
    for (int i = 0; i < 5; i++) call("t4_call", VW'('h500 + i), i, 0);
    step("t4_commit0", 0, '0, 0, 1, 0, 0, 0, 1, 0, 0, 0, '0, 5, 0);
    step("t4_commit1", 0, '0, 0, 1, 0, 0, 0, 1, 0, 0, 0, '0, 5, 1);
    step("t4_redirect", 1, VW'('h999), 0, 0, 0, 1, 0, 1, 0, 0, 0, '0, 5, 2);
    step("t4_unwind0", 0, '0, 1, 0, 0, 0, 0, 0, 0, 1, 0, '0, 5, 2);
    step("t4_unwind1", 0, '0, 1, 0, 0, 1, 0, 0, 0, 1, 0, '0, 4, 2);
    step("t4_unwind2", 0, '0, 1, 0, 0, 0, 0, 0, 0, 1, 0, '0, 3, 2);
    idle("t4_run0", 2, 2);
    idle("t4_run1", 2, 2);
`ifdef BP_FE_RAS_CTRL_STATS_EN
    @(negedge clk_i);
    chk("t4", "unwind_cnt_o", 64'(unwind_cnt_o), 64'd1);
`endif

    // Asynchronous reset during the second unwind cycle
    do_reset("rst4");
    for (int i = 0; i < 5; i++) call("t5_call", VW'('h600 + i), i, 0);
    step("t5_commit0", 0, '0, 0, 1, 0, 0, 0, 1, 0, 0, 0, '0, 5, 0);
    step("t5_commit1", 0, '0, 0, 1, 0, 0, 0, 1, 0, 0, 0, '0, 5, 1);
    step("t5_redirect", 0, '0, 0, 0, 0, 1, 0, 1, 0, 0, 0, '0, 5, 2);
    step("t5_unwind0", 0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0, 5, 2);
    step("t5_unwind1_rst", 0, '0, 0, 0, 0, 0, 1, 1, 0, 0, 0, '0, 0, 0);
    @(negedge clk_i);
    #1;
    reset_i = 1'b0;
    idle("t5_after", 0, 0);

    // Commit saturation, then redirect below commit depth loads spec_depth without unwinding
    do_reset("rst5");
    step("t6_cret_sat", 0, '0, 0, 0, 1, 0, 0, 1, 0, 0, 0, '0, 0, 0);
    call("t6_call", VW'('h700), 0, 0);
    step("t6_cc0", 0, '0, 0, 1, 0, 0, 0, 1, 0, 0, 0, '0, 1, 0);
    step("t6_cc1", 0, '0, 0, 1, 0, 0, 0, 1, 0, 0, 0, '0, 1, 1);
    step("t6_cc2", 0, '0, 0, 1, 0, 0, 0, 1, 0, 0, 0, '0, 1, 2);
    step("t6_redirect", 0, '0, 1, 0, 0, 1, 0, 1, 0, 0, 0, '0, 1, 3);
    idle("t6_run0", 3, 3);
    step("t6_cboth", 0, '0, 0, 1, 1, 0, 0, 1, 0, 0, 0, '0, 3, 3);
    step("t6_cret", 0, '0, 0, 0, 1, 0, 0, 1, 0, 0, 0, '0, 3, 3);
    idle("t6_run1", 3, 2);

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
